opb_register_simulink2ppc_snap: RTL and testbench



---
 rtl/opb_register_simulink2ppc_snap.sv | 93 +++++++++
 tb/tb_opb_register_simulink2ppc_snap.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/opb_register_simulink2ppc_snap.sv
// opb_register_simulink2ppc_snap: OPB readback register with new-data flag, saturating overrun count and freeze.
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h01000C00,
  parameter logic [31:0] C_HIGHADDR   = 32'h01000CFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_valid,
  output logic        user_freeze
);
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] sl_dbus_q, sl_dbus_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        freeze_q, freeze_d;
  logic [15:0] ovr_q, ovr_d;
  logic        in_range, go, rd_data, ctrl_wr, clr_ovr, cap, ovr_inc;
  logic [1:0]  off;
  logic [31:0] rdata;
  logic        unused_in;
  logic [$bits(C_FAMILY)+C_OPB_AWIDTH+C_OPB_DWIDTH-1:0] unused_params;
  assign unused_in     = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29]};
  assign unused_params = {C_FAMILY, {C_OPB_AWIDTH{1'b0}}, {C_OPB_DWIDTH{1'b0}}};
  // Side effects commit on the edge that launches the ack, so a read sees pre-capture DATA.
  always_comb begin
    in_range  = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    off       = OPB_ABus[28:29];
    go        = (state_q == IDLE) && OPB_select && in_range;
    rd_data   = go && OPB_RNW && (off == 2'd0);
    ctrl_wr   = go && !OPB_RNW && (off == 2'd2) && OPB_BE[3];
    clr_ovr   = ctrl_wr && OPB_DBus[31];
    cap       = user_valid && !freeze_q;
    ovr_inc   = cap && valid_q && !rd_data && (ovr_q != 16'hFFFF);
    rdata     = off == 2'd0 ? data_q :
                off == 2'd1 ? {valid_q, freeze_q, 14'd0, ovr_q} :
                off == 2'd2 ? {30'd0, freeze_q, 1'b0} : 32'd0;
    data_d    = cap ? user_data_in : data_q;
    valid_d   = cap ? 1'b1 : rd_data ? 1'b0 : valid_q;
    freeze_d  = ctrl_wr ? OPB_DBus[30] : freeze_q;
    ovr_d     = clr_ovr ? 16'd0 : ovr_inc ? ovr_q + 16'd1 : ovr_q;
    ack_d     = go;
    sl_dbus_d = (go && OPB_RNW) ? rdata : 32'd0;
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = go ? ACK : IDLE;
      ACK:     state_d = WAIT;
      WAIT:    state_d = OPB_select ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      sl_dbus_q <= 32'd0;
      data_q    <= 32'd0;
      valid_q   <= 1'b0;
      freeze_q  <= 1'b0;
      ovr_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      sl_dbus_q <= sl_dbus_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      freeze_q  <= freeze_d;
      ovr_q     <= ovr_d;
    end
  end
  assign Sl_DBus     = sl_dbus_q;
  assign Sl_xferAck  = ack_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_freeze = freeze_q;
endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// tb_opb_register_simulink2ppc_snap: scoreboard bench with a register-level model of the snap register.
module tb_opb_register_simulink2ppc_snap;
  localparam logic [31:0] BASE = 32'h01000C00;
  localparam logic [31:0] HIGH = 32'h01000CFF;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] abus = '0, wdbus = '0, udata = '0;
  logic [3:0]  be = '0;
  logic        rnw = 1'b0, sel = 1'b0, seq = 1'b0, uvalid = 1'b0;
  logic [31:0] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout, ufreeze;
  typedef struct {logic [31:0] data; int cyc;} exp_t;
  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0, errors = 0;
  logic        rst_prev = 1'b1;
  logic        done = 1'b0;
  logic        exp_freeze = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0, m_freeze = 1'b0;
  int          m_ovr = 0;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(wdbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(sl_ack), .Sl_errAck(sl_err), .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .user_data_in(udata), .user_valid(uvalid), .user_freeze(ufreeze)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_prev <= rst_n;
  end

  function automatic logic [31:0] model_read(input logic [1:0] off);
    logic [15:0] o16;
    o16 = m_ovr[15:0];
    case (off)
      2'd0:    return m_data;
      2'd1:    return {m_valid, m_freeze, 14'd0, o16};
      2'd2:    return {30'd0, m_freeze, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of register behaviour, expressed as the register rules.
  task automatic model_step(input logic rd_data, input logic clr, input logic fwr,
                            input logic fval, input logic uv, input logic [31:0] ud);
    logic captured;
    captured = uv && !m_freeze;
    if (captured) begin
      if (m_valid && !rd_data && m_ovr < 65535) m_ovr = m_ovr + 1;
      m_data = ud;
      m_valid = 1'b1;
    end else if (rd_data) m_valid = 1'b0;
    if (fwr) m_freeze = fval;
    if (clr) m_ovr = 0;
  endtask

  task automatic bus(input logic [31:0] a, input logic r, input logic [3:0] b,
                     input logic [31:0] wd, input logic uv, input logic [31:0] ud, input int hold);
    logic in_r, fwr;
    logic [1:0] off;
    @(posedge clk); #1;
    abus = a; rnw = r; be = b; wdbus = wd; sel = 1'b1; uvalid = uv; udata = ud;
    in_r = (a >= BASE) && (a <= HIGH);
    off = a[3:2];
    if (in_r) sb.push_back('{r ? model_read(off) : 32'd0, cyc + 1});
    fwr = in_r && !r && off == 2'd2 && b[0];
    model_step(in_r && r && off == 2'd0, fwr && wd[0], fwr, wd[1], uv, ud);
    @(posedge clk); #1;
    uvalid = 1'b0;
    exp_freeze = m_freeze;
    for (int i = 1; i < hold; i++) @(posedge clk);
    #1 sel = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic cap(input logic [31:0] d);
    @(posedge clk); #1;
    uvalid = 1'b1; udata = d;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
    @(posedge clk); #1;
    uvalid = 1'b0;
    exp_freeze = m_freeze;
  endtask

  always @(negedge clk) begin
    if (!rst_prev) begin
      checks++;
      if (sl_ack !== 1'b0 || sl_dbus !== 32'd0 || ufreeze !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: ack=%b dbus=%h freeze=%b, required all 0", sl_ack, sl_dbus, ufreeze);
      end
    end else begin
      checks++;
      if (ufreeze !== exp_freeze) begin
        errors++;
        $display("FAIL user_freeze at cycle %0d: got %b, required %b", cyc, ufreeze, exp_freeze);
      end
      checks++;
      if ({sl_err, sl_retry, sl_tout} !== 3'b000) begin
        errors++;
        $display("FAIL tied_outputs: got %b, required 000", {sl_err, sl_retry, sl_tout});
      end
      if (sl_ack === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack at cycle %0d: dbus=%h, required no ack", cyc, sl_dbus);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (sl_dbus !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL ack_data: got %h at cycle %0d, required %h at cycle %0d", sl_dbus, cyc, e.data, e.cyc);
          end
        end
      end else begin
        checks++;
        if (sl_dbus !== 32'd0) begin
          errors++;
          $display("FAIL idle_dbus at cycle %0d: got %h, required 00000000", cyc, sl_dbus);
        end
        if (sb.size() != 0 && cyc > sb[0].cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_ack: cycle %0d, required ack at cycle %0d with %h", cyc, sb[0].cyc, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
    if (done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL pending_acks: got %0d outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bus(BASE + 4, 1, 4'hF, 0, 0, 0, 1);
    cap(32'hDEADBEEF);
    bus(BASE, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE + 4, 1, 4'hF, 0, 0, 0, 1);
    cap(32'h00000011); cap(32'h00000022); cap(32'h00000033);
    bus(BASE + 4, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE + 8, 0, 4'hF, 32'h1, 0, 0, 1);
    bus(BASE + 4, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE + 8, 0, 4'hF, 32'h2, 0, 0, 1);
    cap(32'h12345678);
    bus(BASE, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE + 4, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE + 8, 0, 4'b1110, 32'h0, 0, 0, 1);
    bus(BASE + 8, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE + 8, 0, 4'hF, 32'h0, 0, 0, 1);
    cap(32'h00001111);
    bus(BASE, 1, 4'hF, 0, 1, 32'hA5A5A5A5, 1);
    bus(BASE + 4, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE, 0, 4'hF, 32'hFFFFFFFF, 0, 0, 1);
    bus(BASE + 12, 1, 4'hF, 0, 0, 0, 1);
    bus(BASE + 4, 1, 4'hF, 0, 0, 0, 5);
    bus(32'h01000D00, 1, 4'hF, 0, 0, 0, 1);
    bus(32'h01000BFC, 1, 4'hF, 0, 0, 0, 1);
    bus(HIGH - 3, 1, 4'hF, 0, 0, 0, 1);
    @(posedge clk); #1;
    abus = BASE + 4; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    sb.push_back('{model_read(2'd1), cyc + 1});
    @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    m_data = '0; m_valid = 1'b0; m_freeze = 1'b0; m_ovr = 0; exp_freeze = 1'b0;
    sb.push_back('{32'd0, cyc + 1});
    @(posedge clk); #1 sel = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: cap($urandom);
        1: bus(BASE + 4 * $urandom_range(0, 3), 1, 4'hF, 0, 1'($urandom_range(0, 1)), $urandom, 1);
        2: bus(BASE + 8, 0, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1);
        3: bus(BASE + 4 * $urandom_range(0, 3), 0, 4'hF, $urandom, 1'($urandom_range(0, 1)), $urandom, 1);
        default: bus(($urandom_range(0, 1) != 0) ? HIGH + 1 + $urandom_range(0, 255) : BASE - 4 - $urandom_range(0, 255),
                     1, 4'hF, 0, 1'($urandom_range(0, 1)), $urandom, 1);
      endcase
    end
    repeat (5) @(posedge clk);
    done = 1'b1;
  end
endmodule
